// File: rtl/ara_wbeat_capture.sv
// Passive multi-port AXI W-beat capture: snooped strobed beats inside a trigger
// window are queued per port and drained round-robin through one valid/ready port.

module ara_wbeat_capture_fifo #(
  parameter int Width = 8,
  parameter int Depth = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [Width-1:0] din,
  input  logic             pop,
  output logic [Width-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             empty_nxt
);
  localparam int AW = $clog2(Depth);
  localparam logic [AW:0]   CntOne  = 1;
  localparam logic [AW:0]   CntFull = (AW+1)'(Depth);
  localparam logic [AW-1:0] PtrOne  = 1;

  logic [Width-1:0] mem [Depth];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      cnt, cnt_nxt;

  assign dout      = mem[rptr];
  assign empty     = (cnt == '0);
  assign full      = (cnt == CntFull);
  assign empty_nxt = (cnt_nxt == '0);

  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop)      cnt_nxt = cnt + CntOne;
    else if (pop && !push) cnt_nxt = cnt - CntOne;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + PtrOne;
      if (pop)  rptr <= rptr + PtrOne;
      cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= din;
  end
endmodule

module ara_wbeat_capture #(
  parameter int          NrPorts    = 1,
  parameter int          DataWidth  = 256,
  parameter int          FifoDepth  = 16,
  parameter logic [63:0] TriggerOn  = 64'h1,
  parameter logic [63:0] TriggerOff = 64'hFFFF_FFFF_FFFF_FFFF,
  localparam int         SW = DataWidth / 8,
  localparam int         PW = (NrPorts > 1) ? $clog2(NrPorts) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NrPorts*DataWidth-1:0] w_data_i,
  input  logic [NrPorts*SW-1:0]     w_strb_i,
  input  logic [NrPorts-1:0]        w_valid_i,
  input  logic [NrPorts-1:0]        w_ready_i,
  input  logic                      cnt_en_i,
  input  logic [63:0]               trigger_i,
  input  logic [63:0]               exit_i,
  output logic [DataWidth-1:0]      out_data_o,
  output logic [SW-1:0]             out_strb_o,
  output logic [PW-1:0]             out_port_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [31:0]               beat_cnt_o,
  output logic [31:0]               drop_cnt_o,
  output logic [1:0]                state_o,
  output logic                      done_o
);
  localparam int EW = DataWidth + SW;

  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_e;

  state_e state_q, state_nxt;
  logic   done_q;
  logic   unused_exit;

  logic [NrPorts-1:0]         fire, push, pop, drop, empty, full, empty_nxt;
  logic [NrPorts-1:0][EW-1:0] head;
  logic [EW-1:0]              head_sel;
  logic [PW-1:0]              last_grant, held_grant, rr_grant, grant;
  logic                       hold_q, rr_valid, hs;
  logic [3:0]                 n_beat, n_drop;
  logic [32:0]                beat_sum, drop_sum;

  assign unused_exit = ^exit_i[63:1];

  for (genvar p = 0; p < NrPorts; p++) begin : g_port
    assign fire[p] = w_valid_i[p] & w_ready_i[p] & cnt_en_i & (|w_strb_i[p*SW +: SW])
                   & (state_q == CAPTURE);
    assign pop[p]  = hs & (grant == PW'(p));
    // A full FIFO popped this cycle has room for the incoming beat.
    assign push[p] = fire[p] & (~full[p] | pop[p]);
    assign drop[p] = fire[p] & full[p] & ~pop[p];

    ara_wbeat_capture_fifo #(.Width(EW), .Depth(FifoDepth)) i_fifo (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .push      (push[p]),
      .din       ({w_data_i[p*DataWidth +: DataWidth], w_strb_i[p*SW +: SW]}),
      .pop       (pop[p]),
      .dout      (head[p]),
      .empty     (empty[p]),
      .full      (full[p]),
      .empty_nxt (empty_nxt[p])
    );
  end

  // Descending scan so the closest non-empty port after last_grant wins.
  always_comb begin
    int idx;
    rr_valid = 1'b0;
    rr_grant = last_grant;
    for (int i = NrPorts; i >= 1; i--) begin
      idx = (int'(last_grant) + i) % NrPorts;
      if (!empty[idx]) begin
        rr_valid = 1'b1;
        rr_grant = PW'(idx);
      end
    end
  end

  // A stalled grant stays locked until the consumer accepts it.
  assign grant       = hold_q ? held_grant : rr_grant;
  assign out_valid_o = hold_q | rr_valid;
  assign hs          = out_valid_o & out_ready_i;

  always_comb begin
    head_sel = '0;
    for (int p = 0; p < NrPorts; p++)
      if (grant == PW'(p)) head_sel = head[p];
  end

  assign out_data_o = out_valid_o ? head_sel[EW-1:SW] : '0;
  assign out_strb_o = out_valid_o ? head_sel[SW-1:0]  : '0;
  assign out_port_o = out_valid_o ? grant             : '0;

  always_comb begin
    n_beat = '0;
    n_drop = '0;
    for (int p = 0; p < NrPorts; p++) begin
      n_beat = n_beat + {3'b0, push[p]};
      n_drop = n_drop + {3'b0, drop[p]};
    end
  end

  assign beat_sum = {1'b0, beat_cnt_o} + 33'(n_beat);
  assign drop_sum = {1'b0, drop_cnt_o} + 33'(n_drop);

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: begin
        if (exit_i[0] || (trigger_i == TriggerOff && trigger_i == TriggerOn)) state_nxt = DRAIN;
        else if (trigger_i == TriggerOn)                                       state_nxt = CAPTURE;
      end
      CAPTURE: if (trigger_i == TriggerOff || exit_i[0]) state_nxt = DRAIN;
      DRAIN:   if (&empty_nxt) state_nxt = DONE;
      default: state_nxt = DONE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      done_q     <= 1'b0;
      hold_q     <= 1'b0;
      held_grant <= '0;
      last_grant <= PW'(NrPorts - 1);
      beat_cnt_o <= '0;
      drop_cnt_o <= '0;
    end else begin
      state_q    <= state_nxt;
      done_q     <= (state_nxt == DONE);
      hold_q     <= out_valid_o & ~out_ready_i;
      held_grant <= grant;
      if (hs) last_grant <= grant;
      beat_cnt_o <= beat_sum[32] ? '1 : beat_sum[31:0];
      drop_cnt_o <= drop_sum[32] ? '1 : drop_sum[31:0];
    end
  end

  assign state_o = state_q;
  assign done_o  = done_q;
endmodule
